// File: rtl/logic_cluster_k_if.sv
// logic_cluster_k_if: cluster config/data bus; optional ce under LOGIC_CLUSTER_CE_EN
interface logic_cluster_k_if #(
  parameter int NUM_BLE    = 4,
  parameter int NUM_INPUTS = 10
);
  logic                  prog_en;
  logic                  prog_in;
  logic [NUM_INPUTS-1:0] in;
`ifdef LOGIC_CLUSTER_CE_EN
  logic                  ce;
`endif
  logic [NUM_BLE-1:0]    out;
  logic                  prog_out;
  logic                  cfg_valid;
  logic                  cfg_err;
`ifdef LOGIC_CLUSTER_CE_EN
  modport master (output prog_en, prog_in, in, ce, input out, prog_out, cfg_valid, cfg_err);
  modport slave  (input prog_en, prog_in, in, ce, output out, prog_out, cfg_valid, cfg_err);
`else
  modport master (output prog_en, prog_in, in, input out, prog_out, cfg_valid, cfg_err);
  modport slave  (input prog_en, prog_in, in, output out, prog_out, cfg_valid, cfg_err);
`endif
endinterface

// File: rtl/logic_cluster_k.sv
// logic_cluster_k: serially configured K-LUT cluster; BLE flop enable via LOGIC_CLUSTER_CE_EN
module logic_cluster_k #(
  parameter int NUM_BLE    = 4,
  parameter int NUM_INPUTS = 10,
  parameter int LUT_K      = 4
) (
  input logic             clk,
  input logic             rst_n,
  logic_cluster_k_if.slave bus
);
  localparam int SRC      = NUM_INPUTS + NUM_BLE;
  localparam int SEL_W    = $clog2(SRC);
  localparam int SRC_P    = 1 << SEL_W;
  localparam int TT_BITS  = 1 << LUT_K;
  localparam int BLE_BITS = TT_BITS + 1 + LUT_K * SEL_W;
  localparam int CFG_BITS = NUM_BLE * BLE_BITS;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  typedef enum logic [1:0] {UNCFG, LOAD, RUN, ERR} state_t;
  state_t state, state_nx;
  logic [CFG_BITS-1:0] cfg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [NUM_BLE-1:0]  ff, lut, out_v;
  logic [SRC_P-1:0]    src;
  logic                run;
  assign run = state == RUN;
  // configuration chain shifts regardless of state/ce and survives reset for readback
  always_ff @(posedge clk)
    if (bus.prog_en) cfg <= {bus.prog_in, cfg[CFG_BITS-1:1]};
  assign bus.prog_out = cfg[0];
  // next state: any shift means loading; a finished load is judged by its length
  always_comb begin
    state_nx = state;
    if (bus.prog_en) state_nx = LOAD;
    else if (state == LOAD) state_nx = (bit_cnt == CNT_W'(CFG_BITS)) ? RUN : ERR;
  end
  // state, saturating load length counter and registered status decodes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= UNCFG;
      bit_cnt   <= '0;
      bus.cfg_valid <= 1'b0;
      bus.cfg_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.cfg_valid <= state_nx == RUN;
      bus.cfg_err   <= state_nx == ERR;
      if (bus.prog_en)
        bit_cnt <= (state != LOAD) ? CNT_W'(1) :
                   (bit_cnt == CNT_W'(CFG_BITS + 1)) ? bit_cnt : bit_cnt + 1'b1;
    end
  // mux sources: inputs, then flop feedback, unused codes read as 0
  always_comb begin
    src = '0;
    src[SRC-1:0] = {ff, bus.in};
  end
  for (genvar i = 0; i < NUM_BLE; i++) begin : g_ble
    logic [BLE_BITS-1:0] b;
    logic [TT_BITS-1:0]  tt;
    logic [LUT_K-1:0]    li;
    assign b  = cfg[i*BLE_BITS +: BLE_BITS];
    assign tt = b[TT_BITS-1:0];
    for (genvar j = 0; j < LUT_K; j++) begin : g_in
      assign li[j] = src[b[TT_BITS+1+j*SEL_W +: SEL_W]];
    end
    assign lut[i]   = tt[li];
    assign out_v[i] = run && (b[TT_BITS] ? ff[i] : lut[i]);
  end
  assign bus.out = out_v;
  // BLE flops run only in RUN; held at 0 elsewhere so each RUN starts clean
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else if (!run) ff <= '0;
`ifdef LOGIC_CLUSTER_CE_EN
    else if (bus.ce) ff <= lut;
`else
    else ff <= lut;
`endif
endmodule

// File: tb/tb_logic_cluster_k.sv
// tb_logic_cluster_k: directed checks of config load, LUT/flop behaviour and load errors
module tb_logic_cluster_k;
  localparam int N = 132;
  logic clk, rst_n;
  int total = 0, bad = 0;
  logic [N-1:0] v, w;
  logic_cluster_k_if #(.NUM_BLE(4), .NUM_INPUTS(10)) bus ();
  logic_cluster_k dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [9:0] in;
    logic       exp0;
  } vec_t;
  vec_t tbl[8];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic shift(input logic [N-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      bus.prog_en = 1'b1;
      bus.prog_in = (k < N) ? d[k] : 1'b0;
      step();
    end
    bus.prog_en = 1'b0;
    step();
  endtask
  initial begin
    v = '0;
    v[15:0]  = 16'h8000;
    v[16]    = 1'b0;
    v[20:17] = 4'd0;
    v[24:21] = 4'd1;
    v[28:25] = 4'd2;
    v[32:29] = 4'd3;
    v[48:33] = 16'h5555;
    v[49]    = 1'b1;
    v[53:50] = 4'd11;
    v[57:54] = 4'd15;
    v[61:58] = 4'd15;
    v[65:62] = 4'd15;
    w = ~v;
    tbl[0] = '{10'h3FF, 1'b1};
    tbl[1] = '{10'h00F, 1'b1};
    tbl[2] = '{10'h00E, 1'b0};
    tbl[3] = '{10'h00D, 1'b0};
    tbl[4] = '{10'h00B, 1'b0};
    tbl[5] = '{10'h007, 1'b0};
    tbl[6] = '{10'h000, 1'b0};
    tbl[7] = '{10'h3F0, 1'b0};
    bus.prog_en = 1'b0;
    bus.prog_in = 1'b0;
    bus.in      = '1;
`ifdef LOGIC_CLUSTER_CE_EN
    bus.ce = 1'b1;
`endif
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("reset_out", 32'(bus.out), 0);
    chk("reset_valid", 32'(bus.cfg_valid), 0);
    chk("reset_err", 32'(bus.cfg_err), 0);
    shift(v, N);
    chk("load_valid", 32'(bus.cfg_valid), 1);
    chk("load_err", 32'(bus.cfg_err), 0);
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("toggle_%0d", t), 32'(bus.out[1]), 32'(t % 2));
      step();
    end
    for (int t = 0; t < 8; t++) begin
      bus.in = tbl[t].in;
      #1;
      chk($sformatf("and4_%0d", t), 32'(bus.out[0]), 32'(tbl[t].exp0));
      chk($sformatf("idle_ble_%0d", t), 32'(bus.out[3:2]), 0);
    end
    bus.in = '1;
    shift(v, 1);
    chk("pulse_err", 32'(bus.cfg_err), 1);
    chk("pulse_out", 32'(bus.out), 0);
    shift(v, N - 1);
    chk("short_err", 32'(bus.cfg_err), 1);
    chk("short_valid", 32'(bus.cfg_valid), 0);
    chk("short_out", 32'(bus.out), 0);
    shift(v, N + 1);
    chk("long_err", 32'(bus.cfg_err), 1);
    shift(v, N);
    chk("exact_valid", 32'(bus.cfg_valid), 1);
    chk("exact_err", 32'(bus.cfg_err), 0);
    chk("exact_out0", 32'(bus.out[0]), 1);
    begin
      int rb_bad = 0;
      for (int k = 0; k < N; k++) begin
        if (bus.prog_out !== v[k]) rb_bad++;
        bus.prog_en = 1'b1;
        bus.prog_in = w[k];
        step();
      end
      bus.prog_en = 1'b0;
      step();
      chk("readback_mismatches", 32'(rb_bad), 0);
    end
    chk("readback_valid", 32'(bus.cfg_valid), 1);
    for (int k = 0; k < 60; k++) begin
      bus.prog_en = 1'b1;
      bus.prog_in = v[k];
      step();
    end
    rst_n = 1'b0;
    bus.prog_en = 1'b0;
    #1;
    chk("midrst_out", 32'(bus.out), 0);
    chk("midrst_valid", 32'(bus.cfg_valid), 0);
    chk("midrst_err", 32'(bus.cfg_err), 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_valid", 32'(bus.cfg_valid), 0);
    chk("post_rst_err", 32'(bus.cfg_err), 0);
    chk("post_rst_out", 32'(bus.out), 0);
    shift(v, N);
    chk("reload_valid", 32'(bus.cfg_valid), 1);
    chk("reload_out1", 32'(bus.out[1]), 0);
`ifdef LOGIC_CLUSTER_CE_EN
    step();
    chk("ce_run", 32'(bus.out[1]), 1);
    bus.ce = 1'b0;
    step();
    chk("ce_hold_a", 32'(bus.out[1]), 1);
    step();
    chk("ce_hold_b", 32'(bus.out[1]), 1);
    bus.ce = 1'b1;
    step();
    chk("ce_resume", 32'(bus.out[1]), 0);
`else
    step();
    chk("reload_toggle", 32'(bus.out[1]), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
